mmio_io_hub: RTL and testbench
==============================

// Module: mmio_io_hub
// PURPOSE
//   Parametrised memory-mapped I/O peripheral for the minisys CPU.
//   Replaces the fixed 24-bit LED/switch pair with one register block:
//   - LED output register
//   - debounced switch input
//   - rising-edge capture latch with interrupt
//   Sits behind the memory/IO address decoder. Read data is combinational
//   from internal registers to suit the single-cycle datapath; all state
//   updates on clock.
// PARAMETERS
//   LED_W        24     LED output width, 1..32
//   SW_W         24     switch input width, 1..32
//   DEBOUNCE_CYC 20000  prescaler period in clocks between switch samples, >=2
// PORTS
//   clock     in   1      single system clock; all state on rising edge
//   reset     in   1      synchronous, active-high; clears all state
//   iocs      in   1      chip select from the address decoder
//   ioread    in   1      read strobe (qualified by iocs)
//   iowrite   in   1      write strobe (qualified by iocs)
//   ioaddr    in   2      word offset, i.e. byte address [3:2]
//   iowdata   in   32     write data
//   iordata   out  32     read data, combinational
//   switch_i  in   SW_W   raw, asynchronous switch pins
//   led_o     out  LED_W  LED drive, registered
//   irq       out  1      registered interrupt request
// BEHAVIOUR
//   Reset (next edge while reset=1) clears to 0:
//     led_o, ctrl, sync flops, sample register, debounced value, edge latch,
//     prescaler, irq. reset dominates every concurrent access.
//   Register map (ioaddr):
//     0 LED    RW  bits [LED_W-1:0]; reads zero-extend.
//     1 SWITCH RO  debounced value, zero-extended; writes ignored.
//     2 EDGE   R/W1C  per-bit rising-edge latch; write 1 clears a bit, 0 no effect.
//     3 CTRL   RW  bit0 = irq_en; other bits read 0.
//   Write: iocs & iowrite at edge N -> register holds the new value after edge N.
//     Write of LED reaches led_o after edge N.
//   Read: iordata = selected register when iocs & ioread, else 32'h0.
//     Same-cycle read and write returns the pre-write value.
//   Debounce:
//     - 2-flop synchroniser per switch bit.
//     - Prescaler counts 0..DEBOUNCE_CYC-1 and wraps; tick is asserted when
//       count == DEBOUNCE_CYC-1.
//     - On each tick, the synchronised input is stored into the sample register.
//     - A debounced bit takes the synchronised value on a tick only when that
//       value equals the stored sample (stable for 2 consecutive ticks).
//     - Single-tick glitches never propagate.
//   Edge latch: bit set on the edge where its debounced bit goes 0->1.
//     Set and a W1C on the same edge -> bit stays 1 (set wins).
//     Falling edges are not captured.
//   irq: registered, irq <= ctrl.irq_en & |edge_next.
//     Asserts the cycle after the latch sets; drops the cycle after the last
//     bit is cleared or irq_en is written 0.
//   Reset mid-operation: debounce restarts from 0. A switch held high through
//     reset produces a debounced rise, and therefore an edge, 2-3 ticks later.
//   Upper iowdata bits beyond LED_W / SW_W are ignored.
// TESTING (LED_W=24, SW_W=24, DEBOUNCE_CYC=4)
//   1. Reset:
//      assert reset 2 cycles with switch_i=0 -> led_o=0, irq=0, every register
//      reads 0.
//   2. LED write:
//      write 0xABCDEF12 to off 0 -> led_o=24'hCDEF12 next cycle; read off 0 ->
//      0x00CDEF12. Same-cycle read+write of 0x5 returns the old value.
//   3. Debounce:
//      switch_i[3] 0->1 held -> off 1 reads 0x8 within 2 sync + 2 ticks
//      (<=11 clk). A 1-tick pulse on bit 5 never appears.
//   4. Edge+irq:
//      irq_en=1, rise bit 3 -> edge=0x8, irq=1 one clk later. W1C 0x8 -> edge=0,
//      irq=0 next clk. Rise coincident with W1C -> bit stays set.
//   5. Reset mid-operation:
//      hold switch_i=0xFFFFFF, pulse reset -> all cleared, then edge=0xFFFFFF
//      after debounce.
//   6. CTRL:
//      write 0xFFFFFFFF to off 3 -> reads 0x1. irq_en=0 with edges pending ->
//      irq stays 0; write 1 -> irq=1 next clk.

Source files
------------

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: LED output register, debounced switch input and a
// rising-edge capture latch with interrupt. Read data is combinational.
module mmio_io_hub #(
    parameter int LED_W        = 24,
    parameter int SW_W         = 24,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iocs,
    input  logic              ioread,
    input  logic              iowrite,
    input  logic [1:0]        ioaddr,
    input  logic [31:0]       iowdata,
    output logic [31:0]       iordata,
    input  logic [SW_W-1:0]   switch_i,
    output logic [LED_W-1:0]  led_o,
    output logic              irq
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [LED_W-1:0] led_q, led_d;
    logic             ctrl_q, ctrl_d;
    logic [SW_W-1:0]  sync1_q, sync2_q;
    logic [SW_W-1:0]  sample_q, sample_d;
    logic [SW_W-1:0]  deb_q, deb_d;
    logic [SW_W-1:0]  edge_lat_q, edge_lat_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             irq_q, irq_d;
    logic             wr_s, tick_s;
    logic [SW_W-1:0]  w1c_s, stable_s, rise_s;
    logic [31:0]      rdata_s;
    logic             unused_wdata_s;

    // Upper write-data bits beyond the register widths are intentionally dropped.
    assign unused_wdata_s = ^iowdata;

    // Next-state: register writes, prescaler, debounce filter, edge latch, irq.
    always_comb begin
        wr_s     = iocs & iowrite;
        tick_s   = (presc_q == CNT_LAST);
        led_d    = led_q;
        ctrl_d   = ctrl_q;
        w1c_s    = {SW_W{1'b0}};
        sample_d = sample_q;
        deb_d    = deb_q;
        stable_s = ~(sync2_q ^ sample_q);
        if (tick_s) begin
            presc_d = {CNT_W{1'b0}};
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
        if (wr_s) begin
            case (ioaddr)
                2'd0:    led_d  = iowdata[LED_W-1:0];
                2'd2:    w1c_s  = iowdata[SW_W-1:0];
                2'd3:    ctrl_d = iowdata[0];
                default: led_d  = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
        // A bit only follows the synchroniser when it matched the previous tick's sample.
        if (tick_s) begin
            sample_d = sync2_q;
            deb_d    = (deb_q & ~stable_s) | (sync2_q & stable_s);
        end else begin
            sample_d = sample_q;
            deb_d    = deb_q;
        end
        rise_s     = deb_d & ~deb_q;
        edge_lat_d = (edge_lat_q & ~w1c_s) | rise_s;
        irq_d      = ctrl_d & (|edge_lat_d);
    end

    // Combinational read mux; returns pre-write contents on a same-cycle write.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (iocs && ioread) begin
            case (ioaddr)
                2'd0:    rdata_s[LED_W-1:0] = led_q;
                2'd1:    rdata_s[SW_W-1:0]  = deb_q;
                2'd2:    rdata_s[SW_W-1:0]  = edge_lat_q;
                2'd3:    rdata_s[0]         = ctrl_q;
                default: rdata_s            = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q      <= {LED_W{1'b0}};
            ctrl_q     <= 1'b0;
            sync1_q    <= {SW_W{1'b0}};
            sync2_q    <= {SW_W{1'b0}};
            sample_q   <= {SW_W{1'b0}};
            deb_q      <= {SW_W{1'b0}};
            edge_lat_q <= {SW_W{1'b0}};
            presc_q    <= {CNT_W{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            led_q      <= led_d;
            ctrl_q     <= ctrl_d;
            sync1_q    <= switch_i;
            sync2_q    <= sync1_q;
            sample_q   <= sample_d;
            deb_q      <= deb_d;
            edge_lat_q <= edge_lat_d;
            presc_q    <= presc_d;
            irq_q      <= irq_d;
        end
    end

    assign iordata = rdata_s;
    assign led_o   = led_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed self-checking bench for mmio_io_hub with a 4-clock debounce prescaler.
module tb_mmio_io_hub;

    logic        clock;
    logic        reset;
    logic        iocs;
    logic        ioread;
    logic        iowrite;
    logic [1:0]  ioaddr;
    logic [31:0] iowdata;
    logic [31:0] iordata;
    logic [23:0] switch_i;
    logic [23:0] led_o;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic found;

    mmio_io_hub #(.LED_W(24), .SW_W(24), .DEBOUNCE_CYC(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .iocs     (iocs),
        .ioread   (ioread),
        .iowrite  (iowrite),
        .ioaddr   (ioaddr),
        .iowdata  (iowdata),
        .iordata  (iordata),
        .switch_i (switch_i),
        .led_o    (led_o),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        iocs = 1'b1; iowrite = 1'b1; ioaddr = a; iowdata = d;
        step();
        iocs = 1'b0; iowrite = 1'b0; iowdata = 32'h0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        iocs = 1'b1; ioread = 1'b1; ioaddr = a;
        #1;
        check(tag, iordata, exp);
        iocs = 1'b0; ioread = 1'b0;
    endtask

    initial begin
        reset = 1'b1; iocs = 1'b0; ioread = 1'b0; iowrite = 1'b0;
        ioaddr = 2'd0; iowdata = 32'h0; switch_i = 24'h0; found = 1'b0;

        // Reset
        step(); step();
        check("rst_led", {8'h00, led_o}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd("rst_r0", 2'd0, 32'h0);
        rd("rst_r1", 2'd1, 32'h0);
        rd("rst_r2", 2'd2, 32'h0);
        rd("rst_r3", 2'd3, 32'h0);
        reset = 1'b0;

        // LED write, zero-extended read, same-cycle read+write
        wr(2'd0, 32'hABCD_EF12);
        check("led_out", {8'h00, led_o}, 32'h00CD_EF12);
        rd("led_rd", 2'd0, 32'h00CD_EF12);
        iocs = 1'b1; ioread = 1'b1; iowrite = 1'b1; ioaddr = 2'd0; iowdata = 32'h5;
        #1;
        check("rw_old", iordata, 32'h00CD_EF12);
        step();
        iocs = 1'b0; ioread = 1'b0; iowrite = 1'b0; iowdata = 32'h0;
        check("led_new", {8'h00, led_o}, 32'h5);
        rd("led_rd_new", 2'd0, 32'h5);

        // SWITCH is read-only; CTRL keeps only bit 0
        wr(2'd1, 32'hFFFF_FFFF);
        rd("sw_ro", 2'd1, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        rd("ctrl_rd", 2'd3, 32'h1);
        check("irq_idle", {31'h0, irq}, 32'h0);

        // Debounced rise of bit 3 within 11 clocks, with edge and irq
        switch_i = 24'h8;
        for (int k = 0; k < 11 && !found; k++) begin
            step();
            iocs = 1'b1; ioread = 1'b1; ioaddr = 2'd1;
            #1;
            if (iordata === 32'h8) found = 1'b1;
            iocs = 1'b0; ioread = 1'b0;
        end
        check("deb_rise_found", {31'h0, found}, 32'h1);
        rd("edge_set", 2'd2, 32'h8);
        check("irq_set", {31'h0, irq}, 32'h1);
        switch_i = 24'h9;

        // W1C clears the edge and irq on the write edge
        wr(2'd2, 32'h8);
        rd("edge_w1c", 2'd2, 32'h0);
        check("irq_w1c", {31'h0, irq}, 32'h0);

        // Bit 0 rises exactly 8 clocks after the bit-3 tick; W1C on that edge loses
        repeat (6) step();
        wr(2'd2, 32'h1);
        rd("edge_set_wins", 2'd2, 32'h1);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        rd("sw_rd_9", 2'd1, 32'h9);

        // irq_en gating with an edge pending
        wr(2'd3, 32'h0);
        check("irq_en_off", {31'h0, irq}, 32'h0);
        repeat (3) step();
        check("irq_stays_off", {31'h0, irq}, 32'h0);
        wr(2'd3, 32'h1);
        check("irq_en_on", {31'h0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        check("irq_clr", {31'h0, irq}, 32'h0);

        // A one-clock glitch on bit 5 never reaches the debounced value
        switch_i = 24'h29;
        step();
        switch_i = 24'h9;
        for (int k = 0; k < 12; k++) begin
            step();
            rd("glitch_sw", 2'd1, 32'h9);
        end
        rd("glitch_edge", 2'd2, 32'h0);

        // Reset mid-operation with all switches held high
        switch_i = 24'hFF_FFFF;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_led", {8'h00, led_o}, 32'h0);
        check("mid_irq", {31'h0, irq}, 32'h0);
        rd("mid_r0", 2'd0, 32'h0);
        rd("mid_r1", 2'd1, 32'h0);
        rd("mid_r2", 2'd2, 32'h0);
        rd("mid_r3", 2'd3, 32'h0);
        repeat (7) step();
        rd("mid_edge_pre", 2'd2, 32'h0);
        step();
        rd("mid_edge", 2'd2, 32'h00FF_FFFF);
        rd("mid_sw", 2'd1, 32'h00FF_FFFF);
        check("mid_irq_off", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
